// File: rtl/traffic_pkg.sv
// Shared definitions for the three-way intersection: light encodings, fault codes, road indices.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ENCODING  = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_SEQUENCE  = 3'd3;
  localparam logic [2:0] FC_SHORT_GRN = 3'd4;
  localparam logic [2:0] FC_SHORT_YEL = 3'd5;
  localparam logic [2:0] FC_STARVE    = 3'd6;

  localparam logic [1:0] RD_A     = 2'd0;
  localparam logic [1:0] RD_B     = 2'd1;
  localparam logic [1:0] RD_C     = 2'd2;
  localparam logic [1:0] RD_MULTI = 2'd3;

  typedef enum logic [1:0] {StArm, StRun, StFault} mon_state_e;

  // Lowest-indexed flagged road wins, so A beats B beats C.
  function automatic logic [1:0] first_road(input logic [2:0] flags);
    if (flags[0]) return RD_A;
    if (flags[1]) return RD_B;
    return RD_C;
  endfunction

endpackage

// File: rtl/light_dwell_tracker.sv
// Per-road history: previous light, dwell counter, sequence/dwell/starvation checks and
// completed green-phase counter.
module light_dwell_tracker
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MAX_RED    = 64,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PH_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      light,
  input  logic            arm,
  output logic            seq_err,
  output logic            short_green,
  output logic            short_yellow,
  output logic            starve,
  output logic [PH_W-1:0] phases
);

  localparam logic [CNT_W-1:0] DwellSat   = '1;
  localparam logic [CNT_W-1:0] DwellOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MinGreenC  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MinYellowC = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W:0]   MaxRedC    = (CNT_W + 1)'(MAX_RED);

  logic [2:0]      prev_q;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [PH_W-1:0] phases_q, phases_d;
  logic            same, legal_step, green_to_yellow;

  always_comb begin
    same            = (light == prev_q);
    legal_step      = ((prev_q == LT_RED) && (light == LT_GRN)) ||
                      ((prev_q == LT_GRN) && (light == LT_YEL)) ||
                      ((prev_q == LT_YEL) && (light == LT_RED));
    green_to_yellow = (prev_q == LT_GRN) && (light == LT_YEL);

    seq_err      = !same && !legal_step;
    short_green  = green_to_yellow && (dwell_q < MinGreenC);
    short_yellow = (prev_q == LT_YEL) && (light == LT_RED) && (dwell_q < MinYellowC);
    // Widened so a saturated counter can never alias back onto MAX_RED.
    starve       = (prev_q == LT_RED) && (light == LT_RED) &&
                   (((CNT_W + 1)'(dwell_q) + (CNT_W + 1)'(1)) == MaxRedC);

    if (arm || !same) begin
      dwell_d = DwellOne;
    end else if (dwell_q == DwellSat) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + DwellOne;
    end

    phases_d = phases_q;
    if (!arm && green_to_yellow && !short_green) begin
      phases_d = phases_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= LT_RED;
      dwell_q  <= '0;
      phases_q <= '0;
    end else begin
      prev_q   <= light;
      dwell_q  <= dwell_d;
      phases_q <= phases_d;
    end
  end

  assign phases = phases_q;

endmodule

// File: rtl/three_way_light_monitor.sv
// Passive safety monitor for the three-way intersection lights: latches the first violation
// as a sticky fault and counts completed green phases per road.
module three_way_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MAX_RED    = 64,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PH_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      road_a,
  input  logic [2:0]      road_b,
  input  logic [2:0]      road_c,
  input  logic            fault_clr,
  output logic            fault,
  output logic [2:0]      fault_code,
  output logic [1:0]      fault_road,
  output logic [PH_W-1:0] phases_a,
  output logic [PH_W-1:0] phases_b,
  output logic [PH_W-1:0] phases_c
);

  mon_state_e      state_q;
  logic            fault_q;
  logic [2:0]      code_q;
  logic [1:0]      road_q;

  logic [2:0]      lights [3];
  logic [PH_W-1:0] phases [3];
  logic [2:0]      seq_err, short_green, short_yellow, starve;
  logic [2:0]      enc_err, non_red;
  logic            arm, conflict, viol;
  logic [2:0]      viol_code;
  logic [1:0]      viol_road;

  assign lights[0] = road_a;
  assign lights[1] = road_b;
  assign lights[2] = road_c;
  assign arm       = (state_q == StArm);

  for (genvar i = 0; i < 3; i++) begin : g_road
    light_dwell_tracker #(
      .MIN_GREEN  (MIN_GREEN),
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_RED    (MAX_RED),
      .CNT_W      (CNT_W),
      .PH_W       (PH_W)
    ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .light        (lights[i]),
      .arm          (arm),
      .seq_err      (seq_err[i]),
      .short_green  (short_green[i]),
      .short_yellow (short_yellow[i]),
      .starve       (starve[i]),
      .phases       (phases[i])
    );
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      enc_err[i] = !$onehot(lights[i]);
      non_red[i] = |lights[i][1:0];
    end
    conflict = (non_red[0] & non_red[1]) | (non_red[0] & non_red[2]) |
               (non_red[1] & non_red[2]);

    viol_code = FC_NONE;
    viol_road = RD_A;
    if (|enc_err) begin
      viol_code = FC_ENCODING;
      viol_road = first_road(enc_err);
    end else if (conflict) begin
      viol_code = FC_CONFLICT;
      viol_road = RD_MULTI;
    end else if (!arm) begin
      // History-based checks need a sample already loaded into prev.
      if (|seq_err) begin
        viol_code = FC_SEQUENCE;
        viol_road = first_road(seq_err);
      end else if (|short_green) begin
        viol_code = FC_SHORT_GRN;
        viol_road = first_road(short_green);
      end else if (|short_yellow) begin
        viol_code = FC_SHORT_YEL;
        viol_road = first_road(short_yellow);
      end else if (|starve) begin
        viol_code = FC_STARVE;
        viol_road = first_road(starve);
      end
    end
    viol = (viol_code != FC_NONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StArm;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      road_q  <= RD_A;
    end else begin
      case (state_q)
        StArm, StRun: begin
          if (viol) begin
            state_q <= StFault;
            fault_q <= 1'b1;
            code_q  <= viol_code;
            road_q  <= viol_road;
          end else begin
            state_q <= StRun;
          end
        end
        StFault: begin
          // A violation arriving with the clear pulse replaces the old one.
          if (fault_clr) begin
            if (viol) begin
              code_q <= viol_code;
              road_q <= viol_road;
            end else begin
              state_q <= StRun;
              fault_q <= 1'b0;
              code_q  <= FC_NONE;
              road_q  <= RD_A;
            end
          end
        end
        default: state_q <= StArm;
      endcase
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_road = road_q;
  assign phases_a   = phases[0];
  assign phases_b   = phases[1];
  assign phases_c   = phases[2];

endmodule

// File: doc/three_way_light_monitor.md
Name: three_way_light_monitor

Overview:
- Passive safety monitor for the three-way intersection.
- Sits downstream of three_way_traffic_light_controller and samples its road_a/road_b/road_c light outputs every clock.
- Checks encoding, mutual exclusion, phase sequence and dwell times, and latches the first violation as a sticky fault for the fail-safe flasher.
- Also counts completed green phases per road for diagnostics.

Parameters:
- MIN_GREEN, 4: minimum cycles a road must hold green before going yellow.
- MIN_YELLOW, 2: minimum cycles a road must hold yellow before going red.
- MAX_RED, 64: red dwell (cycles) at which a road is declared starved.
- CNT_W, 8: width of the per-road dwell counters; must satisfy 2^CNT_W-1 >= MAX_RED.
- PH_W, 16: width of the per-road green-phase counters.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- road_a  input  3  road A light, {red,yellow,green}: 100=red, 010=yellow, 001=green.
- road_b  input  3  road B light, same encoding.
- road_c  input  3  road C light, same encoding.
- fault_clr  input  1  synchronous pulse; clears the latched fault.
- fault  output  1  sticky fault flag.
- fault_code  output  3  0 none, 1 bad encoding, 2 conflict, 3 bad sequence, 4 short green, 5 short yellow, 6 red starvation.
- fault_road  output  2  0=A, 1=B, 2=C; 3 for conflict (multi-road).
- phases_a  output  PH_W  completed green phases on A.
- phases_b  output  PH_W  completed green phases on B.
- phases_c  output  PH_W  completed green phases on C.

Behaviour:
Reset values:
- fault=0, fault_code=0, fault_road=0, phases_*=0.
- Per-road prev=100 (red), dwell counters=0.
- FSM=ARM.

FSM:
- ARM lasts exactly one cycle after reset deassertion. It loads prev registers from the inputs and sets dwell=1. Encoding and conflict checks are active; sequence and timing checks are not. Always goes to RUN, or to FAULT if a check fires.
- RUN: all checks active. Goes to FAULT on any check firing.
- FAULT: returns to RUN on fault_clr.

Dwell counters:
- Per road: if input == prev then dwell+1, saturating at 2^CNT_W-1; else dwell=1.
- prev is updated to the input each cycle.

Checks (evaluated combinationally on the current inputs vs prev/dwell):
- Encoding: an input that is not one-hot -> code 1.
- Conflict: more than one road non-red (green or yellow) in the same cycle -> code 2.
- Sequence: the only legal changes are red->green, green->yellow and yellow->red. Any other change -> code 3.
- Short green: green->yellow while dwell < MIN_GREEN -> code 4.
- Short yellow: yellow->red while dwell < MIN_YELLOW -> code 5.
- Starvation: red with dwell+1 == MAX_RED -> code 6. Fires once per red period.

Priority and latching:
- Simultaneous violations resolve by code priority 1>2>3>4>5>6, then road A>B>C.
- Latency: fault, fault_code and fault_road are registered at the edge that samples the offending input, so they are visible 1 cycle after the violation is presented.
- First fault only: while fault=1, new violations are ignored and the code/road are held.
- fault_clr in FAULT: fault=0, fault_code=0, fault_road=0 next cycle.
- fault_clr with a same-cycle violation: the new violation is latched (set wins).
- fault_clr while not faulted has no effect.

Phase counters:
- A legal green->yellow transition increments phases_x, wrapping modulo 2^PH_W.
- Counting continues in the FAULT state.

Reset mid-operation:
- rst asserted at any time immediately forces all reset values, including a latched fault.
- ARM repeats after rst deasserts.

Decomposition:
- Shared package traffic_pkg holds:
  - light encodings LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001;
  - fault code constants FC_NONE..FC_STARVE;
  - road index constants.
- The controller should be migrated to use the same package.
- One sub-module, light_dwell_tracker, is instantiated three times. It contains prev, the dwell counter, the sequence/short-dwell/starvation checks and the phase counter. It outputs per-road violation flags.
- The top level holds the encoding and conflict checks, the priority encoder, the FSM and the fault latch.

Test Plan:
- Drive a legal cycle: A green 4, yellow 2, red; then B; then C; repeat 3 times -> fault=0 throughout, phases_a=phases_b=phases_c=3.
- A and B both green for one cycle -> next cycle fault=1, fault_code=2, fault_road=3; extra violations afterwards leave code unchanged.
- B green held 3 cycles then yellow -> fault_code=4, fault_road=1. Pulse fault_clr -> fault=0, code=0 next cycle.
- C green->red directly -> fault_code=3, fault_road=2. Same-cycle road_a=3'b110 -> fault_code=1, fault_road=0, since encoding has priority.
- Hold road_c red, A and B alternating legally -> fault_code=6, fault_road=2 exactly at C's 64th red cycle, measured from ARM.
- Assert rst mid-fault -> all outputs 0 immediately. First cycle after release, present A yellow -> no sequence fault because ARM skips sequence checks.
